alu_share_arbiter: RTL

Two-port arbiter that time-shares the single combinational ALU between the main execute pipeline (port 0) and the address/branch unit (port 1). Accepts one operation per cycle via valid/ready, drives the ALU from a registered issue stage, and returns each result to the originating port in a per-port response register. Illegal opcodes are trapped before they reach the ALU.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/rr_arbiter2.sv | 35 +++
 rtl/alu_share_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU operation encodings and legality check shared by ALU clients
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_t;

    function automatic logic alu_op_legal(input logic [2:0] op);
        logic legal;
        case (op)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT: legal = 1'b1;
            default:                                    legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin arbiter, pointer names the most recent winner
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] eligible,
    output logic [1:0] grant
);

    logic last_q;
    logic last_d;

    always_comb begin
        grant  = 2'b00;
        last_d = last_q;
        case (eligible)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
        if (grant != 2'b00) begin
            last_d = grant[1];
        end
    end

    // Reset to 1 so port 0 takes the first conflict.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - time-shares one combinational ALU between two request ports
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_result,
    output logic             rsp0_err,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_result,
    output logic             rsp1_err,
    output logic [2:0]       alu_op,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    input  logic [WIDTH-1:0] alu_result
);

    logic [1:0]       eligible;
    logic [1:0]       grant;

    logic             iss_valid_q, iss_valid_d;
    logic             iss_id_q,    iss_id_d;
    logic [2:0]       iss_op_q,    iss_op_d;
    logic [WIDTH-1:0] iss_a_q,     iss_a_d;
    logic [WIDTH-1:0] iss_b_q,     iss_b_d;
    logic             iss_err_q,   iss_err_d;

    logic [1:0]       rsp_valid_q, rsp_valid_d;
    logic [1:0]       rsp_err_q,   rsp_err_d;
    logic [WIDTH-1:0] rsp_res_q [2];
    logic [WIDTH-1:0] rsp_res_d [2];
    logic [1:0]       rsp_ready;
    logic             alu_drive;

    assign rsp_ready = {rsp1_ready, rsp0_ready};

    // A port waits while its previous op sits in the issue stage, or while its result is unconsumed.
    always_comb begin
        eligible[0] = reset_n & req0_valid & ~(iss_valid_q & ~iss_id_q)
                      & (~rsp_valid_q[0] | rsp0_ready);
        eligible[1] = reset_n & req1_valid & ~(iss_valid_q & iss_id_q)
                      & (~rsp_valid_q[1] | rsp1_ready);
    end

    rr_arbiter2 u_arb (
        .clk      (clk),
        .reset_n  (reset_n),
        .eligible (eligible),
        .grant    (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    always_comb begin
        iss_valid_d = grant != 2'b00;
        iss_id_d    = grant[1];
        iss_op_d    = grant[1] ? req1_op : req0_op;
        iss_a_d     = grant[1] ? req1_a  : req0_a;
        iss_b_d     = grant[1] ? req1_b  : req0_b;
        iss_err_d   = ~alu_op_legal(iss_op_d);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            iss_valid_q <= 1'b0;
            iss_id_q    <= 1'b0;
            iss_op_q    <= 3'b000;
            iss_a_q     <= '0;
            iss_b_q     <= '0;
            iss_err_q   <= 1'b0;
        end else begin
            iss_valid_q <= iss_valid_d;
            iss_id_q    <= iss_id_d;
            iss_op_q    <= iss_op_d;
            iss_a_q     <= iss_a_d;
            iss_b_q     <= iss_b_d;
            iss_err_q   <= iss_err_d;
        end
    end

    // Idle or trapped ops present a quiet AND of zeros to the ALU.
    assign alu_drive = iss_valid_q & ~iss_err_q;
    assign alu_op    = alu_drive ? iss_op_q : ALU_AND;
    assign alu_in1   = alu_drive ? iss_a_q  : '0;
    assign alu_in2   = alu_drive ? iss_b_q  : '0;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rsp_valid_d[p] = rsp_valid_q[p] & ~rsp_ready[p];
            rsp_err_d[p]   = rsp_err_q[p];
            rsp_res_d[p]   = rsp_res_q[p];
            if (iss_valid_q && (iss_id_q == 1'(p))) begin
                rsp_valid_d[p] = 1'b1;
                rsp_err_d[p]   = iss_err_q;
                rsp_res_d[p]   = iss_err_q ? '0 : alu_result;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rsp_valid_q  <= 2'b00;
            rsp_err_q    <= 2'b00;
            rsp_res_q[0] <= '0;
            rsp_res_q[1] <= '0;
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            rsp_res_q[0] <= rsp_res_d[0];
            rsp_res_q[1] <= rsp_res_d[1];
        end
    end

    assign rsp0_valid  = rsp_valid_q[0];
    assign rsp0_result = rsp_res_q[0];
    assign rsp0_err    = rsp_err_q[0];
    assign rsp1_valid  = rsp_valid_q[1];
    assign rsp1_result = rsp_res_q[1];
    assign rsp1_err    = rsp_err_q[1];

endmodule
